// File: rtl/gpu_write_queue_pkg.sv
// Shared types for the GPU write queue: drain-FSM states, register indices, queued entry.
package gpu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_MEM_REQ = 2'd1,
        ST_REG_WR  = 2'd2
    } drain_state_e;

    localparam logic [1:0] REG_CTRL     = 2'd0;
    localparam logic [1:0] REG_SCROLL_X = 2'd1;
    localparam logic [1:0] REG_SCROLL_Y = 2'd2;

    localparam int GPU_ADDR_W = 24;
    localparam int GPU_DATA_W = 32;

    typedef struct packed {
        logic [GPU_ADDR_W-1:0] addr;
        logic [GPU_DATA_W-1:0] data;
    } wq_entry_t;

endpackage

// File: rtl/gpu_write_queue_if.sv
// Bus bundle for gpu_write_queue: upstream write strobe, VRAM request/grant, register and status outputs.
interface gpu_write_queue_if #(
    parameter int ADDR_WIDTH     = 24,
    parameter int DATA_WIDTH     = 32,
    parameter int DEPTH          = 8,
    parameter int MEM_ADDR_WIDTH = 16
);
    localparam int LEVEL_WIDTH = $clog2(DEPTH) + 1;

    logic [ADDR_WIDTH-1:0]     waddr;
    logic [DATA_WIDTH-1:0]     wdata;
    logic                      wen;
    logic                      mem_req;
    logic [MEM_ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0]     mem_wdata;
    logic                      mem_gnt;
    logic                      ctrl_enable;
    logic [15:0]               scroll_x;
    logic [15:0]               scroll_y;
    logic [LEVEL_WIDTH-1:0]    level;
    logic                      full;
    logic                      empty;
    logic                      ovf;
    logic                      ovf_clr;
    logic [15:0]               ovf_count;

    modport master (
        output waddr, wdata, wen, mem_gnt, ovf_clr,
        input  mem_req, mem_addr, mem_wdata, ctrl_enable, scroll_x, scroll_y,
        input  level, full, empty, ovf, ovf_count
    );

    modport slave (
        input  waddr, wdata, wen, mem_gnt, ovf_clr,
        output mem_req, mem_addr, mem_wdata, ctrl_enable, scroll_x, scroll_y,
        output level, full, empty, ovf, ovf_count
    );

endinterface

// File: rtl/gpu_write_queue_sync_fifo.sv
// Synchronous FIFO, pointers wrap modulo DEPTH (power of two); dout shows the head combinationally.
// Caller must not push when full without a same-cycle pop, nor pop when empty.
module gpu_sync_fifo #(
    parameter int WIDTH = 56,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic                     empty
);
    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [PW:0]      count_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            if (push && !pop)      count_q <= count_q + 1'b1;
            else if (pop && !push) count_q <= count_q - 1'b1;
        end
    end

    // Storage is not reset; occupancy is tracked by the pointers alone.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= din;
    end

    assign dout  = mem_q[rd_ptr_q];
    assign level = count_q;
    assign full  = (count_q == DEPTH[PW:0]);
    assign empty = (count_q == '0);

endmodule

// File: rtl/gpu_write_queue.sv
// Queues upstream writes and drains them in order to VRAM (addr MSB=0) or display registers (MSB=1); pop one cycle after push.
// Upstream has no backpressure: writes to a full queue are dropped and flagged; GPU_WRITE_QUEUE_OVF_CNT_EN adds a drop counter.
module gpu_write_queue
    import gpu_pkg::*;
#(
    parameter int ADDR_WIDTH     = 24,
    parameter int DATA_WIDTH     = 32,
    parameter int DEPTH          = 8,
    parameter int MEM_ADDR_WIDTH = 16
) (
    input  logic              clk,
    input  logic              rst,
    gpu_write_queue_if.slave  bus
);
    localparam int LW = $clog2(DEPTH) + 1;
    localparam int EW = ADDR_WIDTH + DATA_WIDTH;

    logic                      fifo_push, fifo_pop, fifo_full, fifo_empty, drop;
    logic [EW-1:0]             fifo_dout;
    logic [LW-1:0]             fifo_level;
    logic [ADDR_WIDTH-1:0]     head_addr;
    logic [DATA_WIDTH-1:0]     head_data;
    logic                      unused_head_bits;

    drain_state_e              state_q, state_d;
    logic [MEM_ADDR_WIDTH-1:0] word_q;
    logic [DATA_WIDTH-1:0]     data_q;
    logic                      ctrl_enable_q, ovf_q, mem_req;
    logic [15:0]               scroll_x_q, scroll_y_q;

    gpu_sync_fifo #(.WIDTH(EW), .DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   ({bus.waddr, bus.wdata}),
        .dout  (fifo_dout),
        .level (fifo_level),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign head_addr        = fifo_dout[EW-1:DATA_WIDTH];
    assign head_data        = fifo_dout[DATA_WIDTH-1:0];
    assign unused_head_bits = ^{head_addr[ADDR_WIDTH-2:MEM_ADDR_WIDTH+2], head_addr[1:0]};

    // A pop frees a slot in the same cycle, so a write at full is still accepted then.
    assign fifo_pop  = (state_q == ST_IDLE) && !fifo_empty;
    assign fifo_push = bus.wen && (!fifo_full || fifo_pop);
    assign drop      = bus.wen && fifo_full && !fifo_pop;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (fifo_pop) state_d = head_addr[ADDR_WIDTH-1] ? ST_REG_WR : ST_MEM_REQ;
            ST_MEM_REQ: if (bus.mem_gnt) state_d = ST_IDLE;
            ST_REG_WR:  state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            word_q        <= '0;
            data_q        <= '0;
            ctrl_enable_q <= 1'b0;
            scroll_x_q    <= '0;
            scroll_y_q    <= '0;
            ovf_q         <= 1'b0;
        end else begin
            state_q <= state_d;
            if (fifo_pop) begin
                word_q <= head_addr[MEM_ADDR_WIDTH+1:2];
                data_q <= head_data;
            end
            // word_q[1:0] is byte-address bits [3:2], the register index.
            if (state_q == ST_REG_WR) begin
                case (word_q[1:0])
                    REG_CTRL:     ctrl_enable_q <= data_q[0];
                    REG_SCROLL_X: scroll_x_q    <= data_q[15:0];
                    REG_SCROLL_Y: scroll_y_q    <= data_q[15:0];
                    default:      ;
                endcase
            end
            if (drop)             ovf_q <= 1'b1;
            else if (bus.ovf_clr) ovf_q <= 1'b0;
        end
    end

`ifdef GPU_WRITE_QUEUE_OVF_CNT_EN
    logic [15:0] ovf_count_q;

    always_ff @(posedge clk) begin
        if (rst)                                 ovf_count_q <= '0;
        else if (bus.ovf_clr)                    ovf_count_q <= {15'd0, drop};
        else if (drop && ovf_count_q != 16'hFFFF) ovf_count_q <= ovf_count_q + 16'd1;
    end

    assign bus.ovf_count = ovf_count_q;
`else
    assign bus.ovf_count = 16'd0;
`endif

    assign mem_req         = (state_q == ST_MEM_REQ);
    assign bus.mem_req     = mem_req;
    assign bus.mem_addr    = mem_req ? word_q : '0;
    assign bus.mem_wdata   = mem_req ? data_q : '0;
    assign bus.ctrl_enable = ctrl_enable_q;
    assign bus.scroll_x    = scroll_x_q;
    assign bus.scroll_y    = scroll_y_q;
    assign bus.ovf         = ovf_q;
    assign bus.level       = fifo_level;
    assign bus.full        = fifo_full;
    assign bus.empty       = fifo_empty;

endmodule
